// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO and serializes each popped word as a
// UART frame (start, DataWidth data bits LSB first, StopBits stop bits) on tx.
module fifo_uart_tx #(
  parameter int DataWidth = 8,
  parameter int ClkDiv    = 16,
  parameter int StopBits  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DataWidth-1:0] fifo_data,
  output logic                 read_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BaudW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int BitW  = $clog2(DataWidth + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClkDiv - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DataWidth - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(StopBits - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [BaudW-1:0]       baud_q, baud_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [DataWidth-1:0]   shift_q, shift_d;
  logic                   armed_q;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   baud_wrap;
  logic                   last_stop;

  assign baud_wrap = (baud_q == BaudLast);
  assign last_stop = (state_q == STOP) && baud_wrap && (bit_q == StopLast);

  // Pop either from idle or on the very last stop cycle so frames abut.
  assign read_en = armed_q & enable & ~fifo_empty & ((state_q == IDLE) | last_stop);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    if (state_q != IDLE) baud_d = baud_wrap ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (read_en) begin
          state_d = START;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = fifo_data;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == DataLast) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (bit_q == StopLast) begin
            bit_d = '0;
            if (read_en) begin
              state_d = START;
              shift_d = fifo_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line and frame_done are registered from next-state so they align with state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    done_d = (state_d == STOP) && (baud_d == BaudLast) && (bit_d == StopLast);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= 1'b1;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, line-decoding scoreboard, vector table
// and hand-written sequences for enable drop, mid-frame reset and 2 stop bits.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CD  = 4;
  localparam int FL  = (1 + DW + 1) * CD;

  logic clk = 1'b0, reset_n = 1'b1, enable = 1'b0;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic read_en, tx, busy, frame_done;

  logic enable2 = 1'b0, fifo_empty2 = 1'b1;
  logic [7:0] fifo_data2 = 8'h00;
  logic read_en2, tx2, busy2, frame_done2;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DataWidth(8), .ClkDiv(4), .StopBits(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .read_en(read_en), .tx(tx), .busy(busy),
    .frame_done(frame_done));

  fifo_uart_tx #(.DataWidth(8), .ClkDiv(3), .StopBits(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable2), .fifo_empty(fifo_empty2),
    .fifo_data(fifo_data2), .read_en(read_en2), .tx(tx2), .busy(busy2),
    .frame_done(frame_done2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // FIFO models and scoreboard queue
  logic [7:0] fq[$], fq2[$], exp_q[$];
  logic [7:0] junk;
  logic pop1, pop2;
  int pops = 0, pops2 = 0;

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  always begin
    @(negedge clk); #1;
    fifo_empty  = (fq.size() == 0);
    fifo_data   = (fq.size() != 0) ? fq[0] : 8'h00;
    fifo_empty2 = (fq2.size() == 0);
    fifo_data2  = (fq2.size() != 0) ? fq2[0] : 8'h00;
    #2;
    pop1 = read_en;
    pop2 = read_en2;
    if (read_en)  chk("read_en_while_empty", fifo_empty, 1'b0);
    if (read_en2) chk("read_en2_while_empty", fifo_empty2, 1'b0);
    @(posedge clk); #1;
    if (pop1) begin
      pops++;
      if (fq.size() != 0) junk = fq.pop_front();
    end
    if (pop2) begin
      pops2++;
      if (fq2.size() != 0) junk = fq2.pop_front();
    end
    fifo_empty  = (fq.size() == 0);
    fifo_data   = (fq.size() != 0) ? fq[0] : 8'h00;
    fifo_empty2 = (fq2.size() == 0);
    fifo_data2  = (fq2.size() != 0) ? fq2[0] : 8'h00;
  end

  // Line monitor for u_dut: frames sampled mid-bit, data checked against exp_q
  bit         infr = 1'b0;
  int         mcnt = 0, ncyc = 0, last_end = -10, gaps = 0, frames = 0;
  logic [9:0] fbits = '0, last_frame = '0;
  logic [7:0] mw;

  always begin
    @(negedge clk); #2;
    ncyc++;
    if (!reset_n) begin
      infr = 1'b0;
    end else begin
      if (infr) mcnt++;
      else if (tx === 1'b0) begin
        infr  = 1'b1;
        mcnt  = 0;
        fbits = '0;
        if (ncyc != last_end + 1) gaps++;
      end
      chk("busy_vs_line", busy, infr);
      if (infr) begin
        if (mcnt % CD == CD / 2) fbits[mcnt / CD] = tx;
        if (mcnt == FL - 1) begin
          chk("frame_done_last", frame_done, 1'b1);
          infr       = 1'b0;
          last_end   = ncyc;
          frames++;
          last_frame = fbits;
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_extra_frame: got frame 0x%0h, nothing expected", fbits);
          end else begin
            mw = exp_q.pop_front();
            chk("sb_data", fbits[8:1], mw);
            chk("sb_start_stop", {fbits[9], fbits[0]}, 2'b10);
          end
        end else if (frame_done) chk("frame_done_early", frame_done, 1'b0);
      end else if (frame_done) chk("frame_done_idle", frame_done, 1'b0);
    end
  end

  task automatic wait_frames(input int target, input int bound, input string name);
    int c = 0;
    while (frames < target && c < bound) begin
      @(negedge clk); #3;
      c++;
    end
    chk(name, frames >= target, 1'b1);
  endtask

  typedef struct {
    logic [7:0] word;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, p0, c;
    logic [9:0]  a5_bits, f96, f69, f3d;
    logic [10:0] ff_frame, zz_frame;
    logic        eb;
    int          b;

    vecs[0] = '{word: 8'h00, frame: 10'b1000000000};
    vecs[1] = '{word: 8'hFF, frame: 10'b1111111110};
    vecs[2] = '{word: 8'h01, frame: 10'b1000000010};
    vecs[3] = '{word: 8'h80, frame: 10'b1100000000};
    vecs[4] = '{word: 8'h5A, frame: 10'b1010110100};
    vecs[5] = '{word: 8'hC3, frame: 10'b1110000110};
    a5_bits  = 10'b1101001010;
    f96      = 10'b1100101100;
    f69      = 10'b1011010010;
    f3d      = 10'b1001111010;
    ff_frame = 11'b11111111110;
    zz_frame = 11'b11000000000;

    // Reset held with a word waiting and enable high
    push(8'hA5);
    enable = 1'b1;
    #1 reset_n = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      chk("t1_rst_tx", tx, 1'b1);
      chk("t1_rst_busy", busy, 1'b0);
      chk("t1_rst_read_en", read_en, 1'b0);
      chk("t1_rst_frame_done", frame_done, 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #3 chk("t1_not_armed", read_en, 1'b0);
    @(negedge clk); #3;
    chk("t1_armed_pop", read_en, 1'b1);

    // Single 0xA5 frame, cycle by cycle
    p0 = pops;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk); #1;
      if (k <= 40) chk("t2_tx", tx, a5_bits[(k - 1) / 4]);
      if (k == 39) chk("t2_done_early", frame_done, 1'b0);
      if (k == 40) chk("t2_frame_done", frame_done, 1'b1);
      if (k == 40) chk("t2_busy_last", busy, 1'b1);
      if (k == 41) chk("t2_busy_low", busy, 1'b0);
    end
    chk("t2_one_pop", pops - p0, 1);

    // 16 preloaded words drained back to back
    gaps = 0;
    f0 = frames;
    p0 = pops;
    @(negedge clk);
    for (int i = 0; i < 16; i++) push(i[7:0]);
    c = 0;
    while (frames < f0 + 16 && c < 800) begin
      @(negedge clk); #3;
      c++;
    end
    chk("t3_elapsed", c, 640);
    chk("t3_pops", pops - p0, 16);
    chk("t3_no_gaps", gaps, 1);
    @(negedge clk); #1;
    chk("t3_idle_busy", busy, 1'b0);
    chk("t3_idle_tx", tx, 1'b1);
    chk("t3_fifo_empty", fifo_empty, 1'b1);

    // Vector table: one word per frame
    foreach (vecs[i]) begin
      f0 = frames;
      p0 = pops;
      @(negedge clk);
      push(vecs[i].word);
      wait_frames(f0 + 1, 60, "tbl_timeout");
      chk("tbl_frame", last_frame, vecs[i].frame);
      chk("tbl_pops", pops - p0, 1);
      repeat (2) @(negedge clk);
    end

    // Enable dropped during data bit 3
    f0 = frames;
    p0 = pops;
    @(negedge clk);
    push(8'h96);
    push(8'h69);
    for (int k = 1; k <= 18; k++) @(negedge clk);
    enable = 1'b0;
    wait_frames(f0 + 1, 60, "t4_timeout");
    chk("t4_frame", last_frame, f96);
    repeat (20) @(negedge clk);
    #1;
    chk("t4_no_pop", pops - p0, 1);
    chk("t4_idle", busy, 1'b0);
    chk("t4_tx_high", tx, 1'b1);
    @(negedge clk);
    enable = 1'b1;
    wait_frames(f0 + 2, 60, "t4_resume_timeout");
    chk("t4_resume_frame", last_frame, f69);
    chk("t4_pops", pops - p0, 2);

    // Reset during data bit 5 of 0x3C; 0x3D follows
    repeat (2) @(negedge clk);
    f0 = frames;
    p0 = pops;
    @(negedge clk);
    push(8'h3C);
    push(8'h3D);
    for (int k = 1; k <= 26; k++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_tx", tx, 1'b1);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_read_en", read_en, 1'b0);
    mw = exp_q.pop_front();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_frames(f0 + 1, 80, "t5_timeout");
    chk("t5_next_frame", last_frame, f3d);
    chk("t5_frames", frames - f0, 1);
    chk("t5_pops", pops - p0, 2);

    // Two stop bits, ClkDiv=3, back to back
    @(negedge clk);
    enable2 = 1'b1;
    fq2.push_back(8'hFF);
    fq2.push_back(8'h00);
    for (int k = 1; k <= 67; k++) begin
      @(negedge clk); #1;
      if (k <= 33) begin
        b  = (k - 1) / 3;
        eb = ff_frame[b];
      end else if (k <= 66) begin
        b  = (k - 34) / 3;
        eb = zz_frame[b];
      end else begin
        eb = 1'b1;
      end
      chk("t6_tx", tx2, eb);
      chk("t6_frame_done", frame_done2, (k == 33 || k == 66));
      if (k == 34) chk("t6_busy_b2b", busy2, 1'b1);
      if (k == 67) chk("t6_busy_low", busy2, 1'b0);
    end
    chk("t6_pops", pops2, 2);

    chk("sb_leftover", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
